// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
//   owner_t    : which requester was granted the memory in a cycle
//   NOP_INSTR  : instruction word returned for a rejected fetch
//   word_index : byte address -> 30-bit word index (drops bits [1:0])
package imem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      LOAD  = 2'd2
   } owner_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   function automatic logic [29:0] word_index(input logic [31:0] addr);
      return 30'(addr >> 2);
   endfunction

endpackage

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port instruction memory between the IF-stage
// fetch port (reads) and the program loader port (word writes).
// The loader has priority, but after LOAD_BURST_MAX consecutive loader grants
// with a fetch pending, the fetch is granted. Fetch responses are registered
// (exactly one cycle of latency); rejected fetches return NOP_INSTR with f_err.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   f_req/f_addr/f_gnt         fetch request, byte address, accept (comb)
//   f_rvalid/f_rdata/f_err     registered fetch response
//   l_req/l_addr/l_wdata/l_gnt loader write request and accept (comb)
//   m_en/m_we/m_addr/m_wdata   memory control (comb)
//   m_rdata                    memory read data, combinational from m_addr
//   f_stall_cnt                cycles with f_req=1 and f_gnt=0
//                              (only with IMEM_ARB_STALL_STATS_EN defined)
//
// Build option: `define IMEM_ARB_STALL_STATS_EN adds the f_stall_cnt port.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int unsigned DEPTH          = 1024,
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned LOAD_BURST_MAX = 8,
   parameter logic [31:0] NOP_INSTR      = imem_arb_pkg::NOP_INSTR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_req,
   input  logic [31:0]       f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [31:0]       f_rdata,
   output logic              f_err,
   input  logic              l_req,
   input  logic [31:0]       l_addr,
   input  logic [31:0]       l_wdata,
   output logic              l_gnt,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   input  logic [31:0]       m_rdata
`ifdef IMEM_ARB_STALL_STATS_EN
   ,
   output logic [31:0]       f_stall_cnt
`endif
);

   localparam int unsigned     CNT_W     = $clog2(LOAD_BURST_MAX + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(LOAD_BURST_MAX);

   owner_t            r_owner;
   owner_t            w_owner_nxt;
   logic [CNT_W-1:0]  r_burst_cnt;
   logic [31:0]       r_f_rdata;
   logic              r_f_err;

   logic              w_starve;
   logic [29:0]       w_f_word;
   logic [29:0]       w_l_word;
   logic              w_f_addr_ok;
   logic              w_l_addr_ok;

   assign w_f_word    = word_index(f_addr);
   assign w_l_word    = word_index(l_addr);
   assign w_f_addr_ok = (f_addr[1:0] == 2'b00) && ({2'b00, w_f_word} < 32'(DEPTH));
   assign w_l_addr_ok = ({2'b00, w_l_word} < 32'(DEPTH));

   // State register: owner records the grant made in the cycle, so
   // owner==FETCH is exactly "a fetch response is due now".
   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner <= IDLE;
      end else begin
         r_owner <= w_owner_nxt;
      end
   end

   // Next-state: the grant decision. Reset forces no grant.
   always_comb begin
      w_starve    = f_req && (r_burst_cnt == BURST_MAX);
      w_owner_nxt = IDLE;
      if (reset) begin
         w_owner_nxt = IDLE;
      end else if (l_req && !w_starve) begin
         w_owner_nxt = LOAD;
      end else if (f_req) begin
         w_owner_nxt = FETCH;
      end
   end

   // Outputs for the grant being made this cycle.
   always_comb begin
      f_gnt   = 1'b0;
      l_gnt   = 1'b0;
      m_en    = 1'b0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      unique case (w_owner_nxt)
         LOAD: begin
            l_gnt   = 1'b1;
            m_en    = w_l_addr_ok;   // out-of-range writes are acknowledged but dropped
            m_we    = 1'b1;
            m_addr  = ADDR_W'(w_l_word);
            m_wdata = l_wdata;
         end
         FETCH: begin
            f_gnt  = 1'b1;
            m_en   = w_f_addr_ok;
            m_addr = ADDR_W'(w_f_word);
         end
         default: ;
      endcase
   end

   // Fetch response and loader burst counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_f_rdata   <= '0;
         r_f_err     <= 1'b0;
         r_burst_cnt <= '0;
      end else begin
         if (w_owner_nxt == FETCH) begin
            r_f_err   <= !w_f_addr_ok;
            r_f_rdata <= w_f_addr_ok ? m_rdata : NOP_INSTR;
         end
         if (!f_req || (w_owner_nxt == FETCH)) begin
            r_burst_cnt <= '0;
         end else if ((w_owner_nxt == LOAD) && (r_burst_cnt != BURST_MAX)) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
         end
      end
   end

   assign f_rvalid = (r_owner == FETCH);
   assign f_rdata  = r_f_rdata;
   assign f_err    = r_f_err;

`ifdef IMEM_ARB_STALL_STATS_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (f_req && !f_gnt) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign f_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the IF-stage fetch port (read) and the program loader port (word writes).
- Sits between the fetch stage/loader and the memory array. Drives the memory's word-address, enable and write signals.
- Registers the fetch response, so fetch read latency is exactly one cycle.
- Loader has priority, bounded by a burst limit so that fetch is never starved.

Parameters:
DEPTH, 1024, number of 32-bit instruction words in memory
ADDR_W, 10, memory word-index width (clog2(DEPTH))
LOAD_BURST_MAX, 8, max consecutive loader grants while a fetch is pending
NOP_INSTR, 32'h0000_0013, word returned on fetch error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
f_req  in  1  fetch request, held until f_gnt
f_addr  in  32  fetch byte address
f_gnt  out  1  fetch accepted this cycle (combinational)
f_rvalid  out  1  fetch data valid (registered)
f_rdata  out  32  fetched instruction (registered)
f_err  out  1  error qualifier with f_rvalid (misaligned or out of range)
l_req  in  1  loader write request, held until l_gnt
l_addr  in  32  loader byte address; bits [1:0] ignored
l_wdata  in  32  loader write data
l_gnt  out  1  loader write performed this cycle (combinational)
m_en  out  1  memory access enable
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory word index
m_wdata  out  32  memory write data
m_rdata  in  32  memory read data, combinational from m_addr in the same cycle

Behaviour:
- Reset values: f_rvalid=0, f_rdata=0, f_err=0, owner=IDLE, burst_cnt=0. All combinational outputs are 0 while reset is high.
- Owner FSM (registered, records the grant made in the cycle): IDLE, FETCH, LOAD.
- Grant decision, evaluated each cycle:
  - starve = f_req && burst_cnt==LOAD_BURST_MAX.
  - If l_req && !starve: grant loader (next owner LOAD).
  - Else if f_req: grant fetch (next owner FETCH).
  - Else: no grant (next owner IDLE).
- Exactly one grant per cycle. f_gnt and l_gnt are never both high.
- burst_cnt:
  - Increments (saturating at LOAD_BURST_MAX) on a loader grant while f_req=1.
  - Clears on any fetch grant and on any cycle with f_req=0.
- Loader grant:
  - m_en=1, m_we=1, m_addr=l_addr[ADDR_W+1:2], m_wdata=l_wdata.
  - l_addr with word index >= DEPTH: l_gnt still asserted, but m_en=0 (write dropped).
- Fetch grant, valid address:
  - m_en=1, m_we=0, m_addr=f_addr[ADDR_W+1:2].
  - m_rdata is captured into f_rdata at the clock edge.
  - Next cycle: f_rvalid=1, f_err=0.
- Fetch grant, bad address (f_addr[1:0]!=0, or f_addr[31:2] >= DEPTH):
  - m_en=0.
  - Next cycle: f_rvalid=1, f_err=1, f_rdata=NOP_INSTR.
- f_rvalid is a one-cycle pulse per fetch grant. Back-to-back fetch grants give f_rvalid high on consecutive cycles.
- f_rdata holds its last value when f_rvalid=0.
- m_wdata=0 and m_we=0 whenever there is no loader grant.
- Read-after-write: a fetch granted in the cycle after a loader write to the same word returns the new data.
- Reset mid-operation: a response due the next cycle is cancelled (f_rvalid=0), and burst_cnt and owner clear.

Optional Feature:
- Macro IMEM_ARB_STALL_STATS_EN.
- Defined:
  - Adds output port f_stall_cnt, 32 bits.
  - Increments on every cycle with f_req=1 and f_gnt=0. Wraps at 2^32.
  - Cleared by reset.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package imem_arb_pkg holds: owner_t enum (IDLE/FETCH/LOAD), NOP_INSTR constant, and the word-index extraction function.
- Single module. No sub-module is natural; the burst counter stays inline.

Test Plan:
1. Memory preloaded with word[3]=32'hDEADBEEF; fetch-only request f_addr=0x0C, f_req=1 for one cycle -> f_gnt same cycle; next cycle f_rvalid=1, f_rdata=32'hDEADBEEF, f_err=0.
2. Loader writes 32'h12345678 at 0x40, then fetch 0x40 in the following cycle -> f_rdata=32'h12345678.
3. l_req and f_req held high continuously, LOAD_BURST_MAX=8 -> pattern is 8 l_gnt, 1 f_gnt, repeating; the f_gnt cycles are cycles 9, 18, and so on.
4. Fetch at 0x0000_0006, and fetch at 0x0000_1000 (DEPTH=1024) -> each returns f_rvalid=1, f_err=1, f_rdata=32'h00000013; m_en=0 in both grant cycles.
5. reset asserted in the cycle after a fetch grant -> f_rvalid=0 in the following cycle, and burst_cnt=0 after reset is released.
6. With IMEM_ARB_STALL_STATS_EN defined, f_req held during 5 loader grants -> f_stall_cnt=5.
